// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: microword field
// positions, sequencing-op encodings and the controller state set.
package useq_pkg;

  localparam int unsigned ADDR_HI = 20;
  localparam int unsigned ADDR_LO = 13;
  localparam int unsigned SEQ_HI  = 2;
  localparam int unsigned SEQ_LO  = 0;

  typedef enum logic [2:0] {
    SEQ_NEXT = 3'b000,
    SEQ_JMP  = 3'b001,
    SEQ_MAP  = 3'b010,
    SEQ_BRC  = 3'b011,
    SEQ_BRZ  = 3'b100,
    SEQ_CALL = 3'b101,
    SEQ_RET  = 3'b110,
    SEQ_HALT = 3'b111
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } state_e;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for CALL/RET. Push on full and pop on empty are
// dropped here; the controller flags them as a fault.
module useq_stack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic [7:0]     mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           do_push, do_pop;

  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~do_push;

  // Top-of-stack read: entry just below the stack pointer.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (SPW'(i + 1) == sp_q) dout = mem_q[i];
    end
  end

  // Stack pointer next value.
  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + 1'b1;
    else if (do_pop) sp_d = sp_q - 1'b1;
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      if (do_push) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (SPW'(i) == sp_q) mem_q[i] <= din;
        end
      end
    end
  end

endmodule

// File: rtl/useq_controller.sv
// Microprogram sequencer: fetches a 24-bit microword from the synchronous
// ROM, latches it into the MIR, strobes it to the datapath for one cycle
// and computes the next microaddress. Three cycles per microinstruction.
module useq_controller
  import useq_pkg::*;
#(
  parameter logic [7:0]  RESET_ADDR  = 8'h00,
  parameter logic [3:0]  MAP_BASE    = 4'h8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic [23:0] rom_data,
  input  logic        flag_c,
  input  logic        flag_z,
  input  logic [3:0]  ir_op,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  output logic [23:0] mir,
  output logic        mir_valid,
  output logic [7:0]  upc,
  output logic        halted,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [7:0]  upc_q, upc_d;
  logic [23:0] mir_q, mir_d;
  logic        fault_q, fault_d;
  logic        run_q;

  logic [7:0]  addr_f, upc_inc;
  seq_op_e     seq;
  logic        stop;
  logic        stk_push, stk_pop, stk_full, stk_empty;
  logic [7:0]  stk_dout;

  assign addr_f  = mir_q[ADDR_HI:ADDR_LO];
  assign seq     = seq_op_e'(mir_q[SEQ_HI:SEQ_LO]);
  assign upc_inc = upc_q + 8'd1;

  useq_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (upc_inc),
    .dout (stk_dout),
    .full (stk_full),
    .empty(stk_empty)
  );

  // Next-state, next-address and stack control.
  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    mir_d    = mir_q;
    fault_d  = fault_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stop     = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (!fault_q && ((run && !run_q) || step)) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        mir_d   = rom_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (seq)
          SEQ_NEXT: upc_d = upc_inc;
          SEQ_JMP:  upc_d = addr_f;
          SEQ_MAP:  upc_d = {MAP_BASE, ir_op};
          SEQ_BRC:  upc_d = flag_c ? addr_f : upc_inc;
          SEQ_BRZ:  upc_d = flag_z ? addr_f : upc_inc;
          SEQ_CALL: begin
            if (stk_full) begin
              fault_d = 1'b1;
              stop    = 1'b1;
            end else begin
              stk_push = 1'b1;
              upc_d    = addr_f;
            end
          end
          SEQ_RET: begin
            if (stk_empty) begin
              fault_d = 1'b1;
              stop    = 1'b1;
            end else begin
              stk_pop = 1'b1;
              upc_d   = stk_dout;
            end
          end
          SEQ_HALT: begin
            upc_d = upc_inc;
            stop  = 1'b1;
          end
        endcase
        state_d = (stop || !run) ? ST_HALT : ST_FETCH;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HALT;
      upc_q   <= RESET_ADDR;
      mir_q   <= '0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      mir_q   <= mir_d;
      fault_q <= fault_d;
      run_q   <= run;
    end
  end

  assign rom_addr  = upc_q;
  assign rom_en    = (state_q == ST_FETCH);
  assign mir       = mir_q;
  assign mir_valid = (state_q == ST_EXEC);
  assign upc       = upc_q;
  assign halted    = (state_q == ST_HALT);
  assign fault     = fault_q;

endmodule

// File: tb/tb_useq_controller.sv
// Bench for useq_controller: a behavioural ROM and an instruction-level
// interpreter predict every executed microaddress, microword and final state.
module tb_useq_controller;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, run, step;
  logic [23:0] rom_data;
  logic        flag_c, flag_z;
  logic [3:0]  ir_op;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [23:0] mir;
  logic        mir_valid;
  logic [7:0]  upc;
  logic        halted, fault;

  int errors = 0;
  int checks = 0;

  logic [23:0] rom [256];
  logic        en_s;
  logic [7:0]  addr_s;

  logic [7:0]  m_pc;
  bit          m_fault;
  logic [7:0]  m_stack [$];
  logic [7:0]  exp_pc [$];
  logic [23:0] exp_w [$];

  useq_controller #(
    .RESET_ADDR (8'h00),
    .MAP_BASE   (4'h8),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step     (step),
    .rom_data (rom_data),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .ir_op    (ir_op),
    .rom_addr (rom_addr),
    .rom_en   (rom_en),
    .mir      (mir),
    .mir_valid(mir_valid),
    .upc      (upc),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: address/enable captured mid-cycle, data returned next cycle.
  always @(negedge clk) begin
    en_s   <= rom_en;
    addr_s <= rom_addr;
  end
  always @(posedge clk) if (en_s) rom_data <= rom[addr_s];

  function automatic logic [23:0] mk(input logic [2:0] s, input logic [7:0] a);
    logic [23:0] w;
    w        = 24'($urandom);
    w[20:13] = a;
    w[2:0]   = s;
    return w;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = mk(3'd7, 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 8'h00; m_fault = 1'b0; m_stack.delete();
  endtask

  // Instruction-level interpreter of the sequencing rules.
  task automatic model(input bit free, input int limit);
    logic [23:0] w;
    logic [7:0]  a;
    int          n;
    bit          stop;
    n = 0; stop = 1'b0;
    exp_pc.delete(); exp_w.delete();
    if (m_fault) return;
    while (!stop) begin
      w = rom[m_pc];
      a = w[20:13];
      exp_pc.push_back(m_pc);
      exp_w.push_back(w);
      n++;
      case (w[2:0])
        3'd0: m_pc = m_pc + 8'd1;
        3'd1: m_pc = a;
        3'd2: m_pc = {4'h8, ir_op};
        3'd3: m_pc = flag_c ? a : m_pc + 8'd1;
        3'd4: m_pc = flag_z ? a : m_pc + 8'd1;
        3'd5: begin
          if (m_stack.size() == DEPTH) begin m_fault = 1'b1; stop = 1'b1; end
          else begin m_stack.push_back(m_pc + 8'd1); m_pc = a; end
        end
        3'd6: begin
          if (m_stack.size() == 0) begin m_fault = 1'b1; stop = 1'b1; end
          else m_pc = m_stack.pop_back();
        end
        default: begin m_pc = m_pc + 8'd1; stop = 1'b1; end
      endcase
      if (!free || n >= limit) stop = 1'b1;
    end
  endtask

  // mode 0: start by step, 1: start by run edge, 2: already started.
  // stop_after>0 drops run during the FETCH of that instruction.
  task automatic execute(input string name, input int mode, input int stop_after);
    int cyc, seen, last;
    bit done;
    logic [7:0]  pc_e;
    logic [23:0] w_e;
    cyc = 0; seen = 0; last = -1; done = 1'b0;
    if (mode != 2) begin
      @(negedge clk);
      if (mode == 1) run = 1'b1; else step = 1'b1;
    end
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      step = 1'b0;
      if (mir_valid) begin
        checks++;
        if (exp_pc.size() == 0) begin
          errors++;
          $display("FAIL %s extra_exec upc=%h mir=%h, none expected", name, upc, mir);
        end else begin
          pc_e = exp_pc.pop_front();
          w_e  = exp_w.pop_front();
          if (upc !== pc_e || mir !== w_e) begin
            errors++;
            $display("FAIL %s exec upc=%h mir=%h, expected upc=%h mir=%h", name, upc, mir, pc_e, w_e);
          end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("FAIL %s spacing got %0d cycles, expected 3", name, cyc - last);
          end
        end
        last = cyc;
        seen++;
      end
      if (stop_after > 0 && run && rom_en && seen == stop_after - 1) run = 1'b0;
      if (halted && seen > 0) done = 1'b1;
      else if (!halted && $urandom_range(0, 7) == 0) step = 1'b1;
    end
    run = 1'b0; step = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout halted=%b seen=%0d", name, halted, seen); end
    checks++;
    if (exp_pc.size() != 0) begin
      errors++;
      $display("FAIL %s missing_exec got %0d pending, expected 0", name, exp_pc.size());
    end
    checks++;
    if (upc !== m_pc) begin errors++; $display("FAIL %s final_upc got %h, expected %h", name, upc, m_pc); end
    checks++;
    if (fault !== m_fault) begin errors++; $display("FAIL %s fault got %b, expected %b", name, fault, m_fault); end
  endtask

  task automatic test_reset();
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = mk(3'd0, 8'($urandom));
    rom[3] = mk(3'd7, 8'($urandom));
    rst = 1'b1; run = 1'b1; step = 1'b0;
    flag_c = 1'b0; flag_z = 1'b0; ir_op = 4'h0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (halted !== 1'b1)      begin errors++; $display("FAIL rst_halted got %b, expected 1", halted); end
    if (upc !== 8'h00)        begin errors++; $display("FAIL rst_upc got %h, expected 00", upc); end
    if (mir !== 24'h0)        begin errors++; $display("FAIL rst_mir got %h, expected 000000", mir); end
    if (mir_valid !== 1'b0)   begin errors++; $display("FAIL rst_mir_valid got %b, expected 0", mir_valid); end
    if (rom_en !== 1'b0)      begin errors++; $display("FAIL rst_rom_en got %b, expected 0", rom_en); end
    if (fault !== 1'b0)       begin errors++; $display("FAIL rst_fault got %b, expected 0", fault); end
    m_pc = 8'h00; m_fault = 1'b0; m_stack.delete();
    model(1'b1, 1000);
    rst = 1'b0;
    execute("reset_start", 2, 0);
  endtask

  task automatic test_branch();
    logic [7:0] a;
    bit         isz, f;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      clear_rom();
      isz = (i < 4) ? i[0] : 1'($urandom);
      f   = (i < 4) ? i[1] : 1'($urandom);
      a   = 8'($urandom_range(16, 240));
      rom[0] = mk(isz ? 3'd4 : 3'd3, a);
      if (isz) begin flag_z = f; flag_c = 1'($urandom); end
      else     begin flag_c = f; flag_z = 1'($urandom); end
      model(1'b1, 1000);
      execute(isz ? "brz" : "brc", 1, 0);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    clear_rom();
    rom[8'h00] = mk(3'd5, 8'h20);
    rom[8'h20] = mk(3'd6, 8'($urandom));
    rom[8'h01] = mk(3'd7, 8'($urandom));
    model(1'b1, 1000);
    execute("call_ret", 1, 0);
    rom[8'h02] = mk(3'd6, 8'($urandom));
    model(1'b1, 1000);
    execute("ret_underflow", 1, 0);
  endtask

  task automatic test_overflow();
    int hits;
    do_reset();
    clear_rom();
    for (int k = 0; k < 5; k++) rom[k] = mk(3'd5, 8'(k + 1));
    model(1'b1, 1000);
    execute("overflow", 1, 0);
    hits = 0;
    @(negedge clk); run = 1'b1; step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (6) begin if (rom_en) hits++; @(negedge clk); end
    run = 1'b0; @(negedge clk); step = 1'b1; @(negedge clk); step = 1'b0;
    repeat (6) begin if (rom_en) hits++; @(negedge clk); end
    checks += 2;
    if (hits != 0) begin errors++; $display("FAIL fault_lock rom_en_cycles got %0d, expected 0", hits); end
    if (halted !== 1'b1 || upc !== 8'h04) begin
      errors++;
      $display("FAIL fault_lock halted=%b upc=%h, expected halted=1 upc=04", halted, upc);
    end
  endtask

  task automatic test_step_map();
    do_reset();
    clear_rom();
    ir_op = 4'h5;
    rom[8'h00] = mk(3'd2, 8'($urandom));
    model(1'b0, 1);
    execute("step_map", 0, 0);
    for (int i = 0; i < 6 && !m_fault; i++) begin
      ir_op  = 4'($urandom); flag_c = 1'($urandom); flag_z = 1'($urandom);
      rom[m_pc] = mk(3'($urandom), 8'($urandom));
      model(1'b0, 1);
      execute("step_rand", 0, 0);
    end
  endtask

  task automatic test_run_stop();
    int n;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) rom[i] = mk(3'($urandom_range(0, 4)), 8'($urandom));
      flag_c = 1'($urandom); flag_z = 1'($urandom); ir_op = 4'($urandom);
      n = $urandom_range(3, 8);
      model(1'b1, n);
      execute("run_stop", 1, n);
    end
    do_reset();
    clear_rom();
    rom[8'h00] = mk(3'd1, 8'hFF);
    rom[8'hFF] = mk(3'd0, 8'($urandom));
    model(1'b1, 3);
    execute("wrap", 1, 3);
  endtask

  task automatic test_async_reset();
    int guard, pulses;
    do_reset();
    clear_rom();
    rom[8'h00] = mk(3'd1, 8'h37);
    rom[8'h37] = mk(3'd0, 8'($urandom));
    model(1'b1, 1);
    execute("pre_reset", 1, 1);
    @(negedge clk); run = 1'b1;
    guard = 0;
    while (!rom_en && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (!rom_en) begin errors++; $display("FAIL async_fetch timeout rom_en=%b, expected 1", rom_en); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks += 4;
    if (upc !== 8'h00)      begin errors++; $display("FAIL async_upc got %h, expected 00", upc); end
    if (mir !== 24'h0)      begin errors++; $display("FAIL async_mir got %h, expected 000000", mir); end
    if (halted !== 1'b1)    begin errors++; $display("FAIL async_halted got %b, expected 1", halted); end
    if (mir_valid !== 1'b0) begin errors++; $display("FAIL async_mir_valid got %b, expected 0", mir_valid); end
    run = 1'b0;
    pulses = 0;
    repeat (2) begin @(negedge clk); if (mir_valid) pulses++; end
    rst = 1'b0;
    repeat (6) begin @(negedge clk); if (mir_valid) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL async_no_exec got %0d pulses, expected 0", pulses); end
    m_pc = 8'h00; m_fault = 1'b0; m_stack.delete();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; rom_data = '0;
    flag_c = 1'b0; flag_z = 1'b0; ir_op = 4'h0;
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_step_map();
    test_run_stop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/useq_controller.md
Name: useq_controller

Overview:
Microprogram sequencer that drives the 24-bit microcode ROM and sequences the existing register/ALU datapath, one microinstruction at a time.
- Generates the ROM address and latches the returned microword into a microinstruction register (MIR).
- Presents the MIR to the datapath decoders with a one-cycle execute strobe.
- Computes the next microaddress: increment, jump, opcode map, conditional branch on carry/zero, call/return with a small hardware stack, halt.
- Provides run / single-step control.

Parameters:
- RESET_ADDR, 8'h00, microaddress loaded into upc on reset.
- MAP_BASE, 4'h8, upper nibble of the MAP target address; the target is {MAP_BASE, ir_op}.
- STACK_DEPTH, 4, number of return-address entries; legal range 2..8.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; a rising edge starts free-running execution, low stops it after the current microinstruction.
- step  in  1  one-cycle pulse; while halted, executes exactly one microinstruction.
- rom_data  in  24  synchronous ROM output; valid the cycle after rom_en was high.
- flag_c  in  1  carry flag from the status register.
- flag_z  in  1  zero flag from the status register.
- ir_op  in  4  opcode field of IR; used by MAP.
- rom_addr  out  8  ROM address, always equal to upc.
- rom_en  out  1  ROM read enable.
- mir  out  24  latched microword.
- mir_valid  out  1  execute strobe; datapath register enables are gated by it.
- upc  out  8  current microaddress.
- halted  out  1  sequencer is in the HALT state.
- fault  out  1  sticky stack overflow/underflow error.

Behaviour:
Reset values (asynchronous, while rst=1):
- state=HALT, upc=RESET_ADDR, mir=0, mir_valid=0, rom_en=0, fault=0.
- Stack pointer = 0 (stack empty); the internal run-edge register run_q=0.

Microword fields:
- mir[20:13] is the address field ADDR.
- mir[2:0] is the sequencing op SEQ.
- All other bits pass through untouched.

FSM (3 cycles per microinstruction):
- HALT: halted=1. Go to FETCH when fault=0 and either a run rising edge (run & ~run_q) or step=1. A run level already high when rst deasserts counts as a rising edge.
- FETCH: rom_en=1, rom_addr=upc. Go to DECODE.
- DECODE: mir <= rom_data at end of cycle. Go to EXEC.
- EXEC: mir_valid=1 for exactly this cycle. At the end of the cycle, upc <= next address.
  - If the SEQ is not HALT, no fault occurred, and run=1, go to FETCH.
  - Otherwise go to HALT.

SEQ decode (evaluated in EXEC; flags sampled in the same cycle):
- 000 NEXT: upc+1.
- 001 JMP: ADDR.
- 010 MAP: {MAP_BASE, ir_op}.
- 011 BRC: ADDR if flag_c, else upc+1.
- 100 BRZ: ADDR if flag_z, else upc+1.
- 101 CALL: push upc+1; upc <= ADDR.
- 110 RET: upc <= pop.
- 111 HALT: upc+1, then enter HALT; resume requires a new run rising edge or a step.

Boundary rules:
- upc arithmetic is modulo 256: 8'hFF+1 = 8'h00.
- CALL with stack full: no push, upc unchanged, fault <= 1, enter HALT.
- RET with stack empty: upc unchanged, fault <= 1, enter HALT.
- fault is cleared only by rst; run and step are ignored while fault=1.
- run falling during FETCH or DECODE: the current microinstruction still completes EXEC, then the FSM enters HALT.
- step while not halted: ignored.
- step and a run rising edge in the same HALT cycle: treated as a run start (free-running).
- rst asserted mid-instruction: immediate return to reset values; a partially fetched word is discarded with no mir_valid pulse.
- mir holds its value outside EXEC; mir_valid=0 in all other states.

Decomposition:
- Shared package useq_pkg holds:
  - SEQ op encodings (SEQ_NEXT..SEQ_HALT).
  - Field positions ADDR_HI=20, ADDR_LO=13, SEQ_HI=2, SEQ_LO=0.
  - State encoding for HALT/FETCH/DECODE/EXEC.
- One sub-module, useq_stack: a LIFO of STACK_DEPTH x 8 bits.
  - Inputs: push, pop, din. Outputs: dout, full, empty.
  - Asynchronous active-high reset.
  - Push on full and pop on empty are ignored; the controller reports them as fault.

Test Plan:
- Reset and start: hold rst with run=1, ROM[00..02]=NEXT, ROM[03]=HALT → after rst release, mir_valid pulses every 3rd cycle for upc 00,01,02,03; then halted=1 and upc=04.
- Conditional branch: ROM[00]=BRC ADDR=40. With flag_c=1 → upc=40. Repeat with flag_c=0 → upc=01. Same check for BRZ with flag_z.
- Call/return: ROM[00]=CALL 20, ROM[20]=RET → upc sequence 00,20,01; stack empty at end; fault=0.
- Overflow: ROM[k]=CALL k+1 for k=0..4 → fifth CALL sets fault=1, halted=1, upc=04; subsequent run/step produce no rom_en.
- Single step and MAP: run=0, ir_op=4'h5, ROM[00]=MAP → one step pulse gives exactly one mir_valid and upc=8'h85, then halted again.
- Wrap and async reset: upc=FF with a NEXT word → next upc=00. Assert rst during DECODE → mir_valid never pulses and upc=RESET_ADDR immediately.
